morse_tx_encoder: RTL and testbench
===================================

// Module: morse_tx_encoder
// PURPOSE
//  Morse transmitter: the counterpart of the keyed-input Morse decoder. Accepts a letter
//  index (0=A .. 25=Z) over a valid/ready handshake and drives a timed on/off key line
//  (dots, dashes, intra-character gaps, character gap) using the same tick timing as the
//  decoder. Sits beside the decoder as a demo/self-test source or a buzzer/LED driver.
// PARAMETERS
//  DOT_TIME   20  key-high cycles for a dot
//  DASH_TIME  60  key-high cycles for a dash
//  GAP_TIME   10  key-low cycles between symbols of one letter
//  CHAR_TIME  40  key-low cycles after the last symbol (character gap)
//  CNT_W       6  timer width; must hold max(all *_TIME)-1
// PORTS
//  clk_i     in   1  clock (100 Hz tick domain)
//  rst_ni    in   1  asynchronous active-low reset
//  valid_i   in   1  letter_i valid
//  letter_i  in   5  letter index 0..25
//  ready_o   out  1  block can accept a letter (high only in IDLE)
//  abort_i   in   1  synchronous abort of current letter
//  key_o     out  1  Morse key line, 1=tone/mark
//  busy_o    out  1  transmission in progress (not IDLE)
//  done_o    out  1  1-cycle pulse: letter completed incl. character gap
//  err_o     out  1  1-cycle pulse: letter_i>25 offered and rejected
// BEHAVIOUR
//  Reset: state=IDLE, key_o=0, busy_o=0, done_o=0, err_o=0, ready_o=1; timer, len, code = 0.
//  All outputs are registered or decoded from state only; no combinational path from inputs.
//  Encoding: internal ROM, standard ITU A..Z; {len[2:0], code[3:0]}, first symbol at
//  code[len-1], 1=dash, 0=dot. Examples: A={2,'b01}, B={4,'b1000}, E={1,'b0}, Q={4,'b1101}.
//  Handshake: accept when valid_i&&ready_o at a rising edge. letter_i sampled only then.
//  letter_i>25 at accept: no transmit; err_o=1 next cycle; stays IDLE.
//  FSM: IDLE -> MARK -> (SPACE -> MARK)* -> CGAP -> IDLE.
//   IDLE:  key_o=0. Valid accept -> MARK with timer loaded to (dot|dash time)-1.
//   MARK:  key_o=1; timer counts down; at 0: more symbols -> SPACE (timer=GAP_TIME-1),
//          else -> CGAP (timer=CHAR_TIME-1). Symbol index decrements on MARK exit.
//   SPACE: key_o=0; at timer 0 -> MARK, timer loaded for next symbol.
//   CGAP:  key_o=0; at timer 0 -> IDLE, done_o=1 in the first IDLE cycle.
//  Latency: accept at edge 0 -> key_o=1 in cycles 1..DOT/DASH_TIME. No trailing GAP_TIME
//  after the last symbol (CHAR_TIME replaces it).
//  Back-to-back: ready_o=1 in the same cycle done_o=1; a new letter can be accepted then.
//  abort_i (any state but IDLE): next cycle IDLE, key_o=0, no done_o. abort_i in IDLE: no effect,
//  and abort_i has priority over a simultaneous valid_i (no accept in that cycle).
//  valid_i while busy: ignored (ready_o=0); source must hold it.
//  Async reset mid-letter: key_o drops immediately, state IDLE, no done_o.
//  Timer never wraps; loaded on every state entry, counts down to 0 only.
// CONFIGURATION
//  MORSE_TX_REPEAT_EN defined: adds input repeat_i (1 bit). If repeat_i=1 in the last CGAP
//   cycle, the same letter restarts at MARK (no handshake, done_o still pulses once per letter,
//   ready_o stays 0). abort_i ends repetition.
//  Undefined: no repeat_i port; CGAP always returns to IDLE.
// TESTING
//  1 Reset release, idle 10 cycles -> key_o=0, ready_o=1, busy_o=0, done_o=0, err_o=0.
//  2 Send E (4) -> key_o high exactly cycles 1..20, low 21..60; done_o=1 cycle 61 only.
//  3 Send A (0) -> high 20, low 10, high 60, low 40; done_o at cycle 131; decoder under the
//    same params accepts it as A.
//  4 Send 26, then 31 -> err_o 1-cycle pulse each, key_o stays 0, busy_o stays 0.
//  5 Send Q (16), abort_i at cycle 45 -> key_o=0, busy_o=0 from cycle 46; no done_o; send T
//    next -> key_o high 60 cycles.
//  6 Hold valid_i with T then E back-to-back -> E accepted in the cycle done_o of T is high; E
//    key_o high starts the following cycle. With MORSE_TX_REPEAT_EN, repeat_i=1 sending T:
//    key_o period 100 cycles, done_o every 100.

Source files
------------

// File: rtl/morse_tx_encoder.sv
// Morse key-line transmitter: letter index in, timed ITU mark/space out.
// Optional MORSE_TX_REPEAT_EN adds repeat_i to loop the current letter.
module morse_tx_encoder #(
  parameter int DOT_TIME  = 20,
  parameter int DASH_TIME = 60,
  parameter int GAP_TIME  = 10,
  parameter int CHAR_TIME = 40,
  parameter int CNT_W     = 6
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  logic [4:0] letter_i,
  output logic       ready_o,
  input  logic       abort_i,
`ifdef MORSE_TX_REPEAT_EN
  input  logic       repeat_i,
`endif
  output logic       key_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    CGAP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DOT_LD  = CNT_W'(DOT_TIME - 1);
  localparam logic [CNT_W-1:0] DASH_LD = CNT_W'(DASH_TIME - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_TIME - 1);
  localparam logic [CNT_W-1:0] CHAR_LD = CNT_W'(CHAR_TIME - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       len_q, len_d;
  logic [3:0]       code_q, code_d;
  logic [1:0]       idx_q, idx_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [6:0]       rom;
  logic [2:0]       rom_len;
  logic [3:0]       rom_code;
  logic [1:0]       rom_first;
  logic [1:0]       first_idx;
  logic             rpt;
  logic             tmr_zero;

`ifdef MORSE_TX_REPEAT_EN
  assign rpt = repeat_i;
`else
  assign rpt = 1'b0;
`endif

  function automatic logic [CNT_W-1:0] sym_ld(input logic dash);
    sym_ld = dash ? DASH_LD : DOT_LD;
  endfunction

  // {len, code}; first symbol at code[len-1], 1=dash
  always_comb begin
    rom = 7'd0;
    case (letter_i)
      5'd0:  rom = {3'd2, 4'b0001};
      5'd1:  rom = {3'd4, 4'b1000};
      5'd2:  rom = {3'd4, 4'b1010};
      5'd3:  rom = {3'd3, 4'b0100};
      5'd4:  rom = {3'd1, 4'b0000};
      5'd5:  rom = {3'd4, 4'b0010};
      5'd6:  rom = {3'd3, 4'b0110};
      5'd7:  rom = {3'd4, 4'b0000};
      5'd8:  rom = {3'd2, 4'b0000};
      5'd9:  rom = {3'd4, 4'b0111};
      5'd10: rom = {3'd3, 4'b0101};
      5'd11: rom = {3'd4, 4'b0100};
      5'd12: rom = {3'd2, 4'b0011};
      5'd13: rom = {3'd2, 4'b0010};
      5'd14: rom = {3'd3, 4'b0111};
      5'd15: rom = {3'd4, 4'b0110};
      5'd16: rom = {3'd4, 4'b1101};
      5'd17: rom = {3'd3, 4'b0010};
      5'd18: rom = {3'd3, 4'b0000};
      5'd19: rom = {3'd1, 4'b0001};
      5'd20: rom = {3'd3, 4'b0001};
      5'd21: rom = {3'd4, 4'b0001};
      5'd22: rom = {3'd3, 4'b0011};
      5'd23: rom = {3'd4, 4'b1001};
      5'd24: rom = {3'd4, 4'b1011};
      5'd25: rom = {3'd4, 4'b1100};
      default: rom = 7'd0;
    endcase
  end

  assign rom_len   = rom[6:4];
  assign rom_code  = rom[3:0];
  assign rom_first = 2'(rom_len - 3'd1);
  assign first_idx = 2'(len_q - 3'd1);
  assign tmr_zero  = (timer_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      timer_q <= '0;
      len_q   <= '0;
      code_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      len_q   <= len_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    len_d   = len_q;
    code_d  = code_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (state_q != IDLE && abort_i) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_i && !abort_i) begin
            if (letter_i > 5'd25) begin
              err_d = 1'b1;
            end else begin
              state_d = MARK;
              len_d   = rom_len;
              code_d  = rom_code;
              idx_d   = rom_first;
              timer_d = sym_ld(rom_code[rom_first]);
            end
          end
        end
        MARK: begin
          if (!tmr_zero) begin
            timer_d = timer_q - 1'b1;
          end else if (idx_q != 2'd0) begin
            state_d = SPACE;
            timer_d = GAP_LD;
            idx_d   = idx_q - 2'd1;
          end else begin
            state_d = CGAP;
            timer_d = CHAR_LD;
          end
        end
        SPACE: begin
          if (!tmr_zero) begin
            timer_d = timer_q - 1'b1;
          end else begin
            state_d = MARK;
            timer_d = sym_ld(code_q[idx_q]);
          end
        end
        CGAP: begin
          if (!tmr_zero) begin
            timer_d = timer_q - 1'b1;
          end else begin
            done_d = 1'b1;
            if (rpt) begin
              state_d = MARK;
              idx_d   = first_idx;
              timer_d = sym_ld(code_q[first_idx]);
            end else begin
              state_d = IDLE;
              timer_d = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    key_o   = (state_q == MARK);
    busy_o  = (state_q != IDLE);
    ready_o = (state_q == IDLE);
    done_o  = done_q;
    err_o   = err_q;
  end

endmodule

// File: tb/tb_morse_tx_encoder.sv
// Bench for morse_tx_encoder: expected key-line timeline per letter
// is queued on drive and compared cycle by cycle.
module tb_morse_tx_encoder;

  localparam int DOT  = 20;
  localparam int DASH = 60;
  localparam int GAP  = 10;
  localparam int CHR  = 40;

  logic       clk;
  logic       rst_n;
  logic       valid;
  logic [4:0] letter;
  logic       ready;
  logic       abort;
  logic       rpt;
  logic       key;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic key;
    logic busy;
    logic done;
    logic err;
    logic ready;
  } smp_t;

  typedef struct {
    logic [4:0] letter;
    string      pat;
    bit         is_err;
  } vec_t;

  smp_t sb[$];

  morse_tx_encoder dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .valid_i  (valid),
    .letter_i (letter),
    .ready_o  (ready),
    .abort_i  (abort),
`ifdef MORSE_TX_REPEAT_EN
    .repeat_i (rpt),
`endif
    .key_o    (key),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int c,
                     input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got kbdeR=%b want %b", nm, c, act, exp);
    end
  endtask

  task automatic push(input logic k, input logic b, input logic d,
                      input logic e, input logic r, input int n);
    smp_t s;
    s.key = k; s.busy = b; s.done = d; s.err = e; s.ready = r;
    for (int i = 0; i < n; i++) sb.push_back(s);
  endtask

  task automatic push_letter(input string pat, input bit is_err);
    if (is_err) begin
      push(0, 0, 0, 1, 1, 1);
      push(0, 0, 0, 0, 1, 1);
    end else begin
      for (int i = 0; i < pat.len(); i++) begin
        push(1, 1, 0, 0, 0, (pat[i] == "-") ? DASH : DOT);
        if (i != pat.len() - 1) push(0, 1, 0, 0, 0, GAP);
      end
      push(0, 1, 0, 0, 0, CHR);
      push(0, 0, 1, 0, 1, 1);
    end
  endtask

  // after checking cycle c, drive inputs for the edge that ends cycle c
  task automatic run_sb(input string nm, input int abort_at,
                        input int hold_until, input logic [4:0] hold_letter);
    int c;
    smp_t s;
    c = 0;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      c++;
      s = sb.pop_front();
      cmp(nm, c, {key, busy, done, err, ready},
          {s.key, s.busy, s.done, s.err, s.ready});
      abort = (c == abort_at);
      if (c <= hold_until) begin
        valid  = 1'b1;
        letter = hold_letter;
      end else begin
        valid = 1'b0;
      end
    end
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{5'd4,  ".",    1'b0};
    vecs[1] = '{5'd0,  ".-",   1'b0};
    vecs[2] = '{5'd19, "-",    1'b0};
    vecs[3] = '{5'd1,  "-...", 1'b0};
    vecs[4] = '{5'd16, "--.-", 1'b0};
    vecs[5] = '{5'd25, "--..", 1'b0};
    vecs[6] = '{5'd26, "",     1'b1};
    vecs[7] = '{5'd31, "",     1'b1};
    vecs[8] = '{5'd10, "-.-",  1'b0};

    rst_n = 1'b0; valid = 1'b0; letter = '0; abort = 1'b0; rpt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp("in_reset", 0, {key, busy, done, err, ready}, 5'b00001);
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 0, 0, 0, 1, 10);
    run_sb("idle", 0, 0, 0);

    foreach (vecs[i]) begin
      valid  = 1'b1;
      letter = vecs[i].letter;
      push_letter(vecs[i].pat, vecs[i].is_err);
      run_sb($sformatf("vec%0d", i), 0, 0, 0);
    end

    // abort Q during its first dash
    valid = 1'b1; letter = 5'd16;
    push(1, 1, 0, 0, 0, 45);
    push(0, 0, 0, 0, 1, 3);
    run_sb("abort_q", 45, 0, 0);
    valid = 1'b1; letter = 5'd19;
    push_letter("-", 1'b0);
    run_sb("t_after_abort", 0, 0, 0);

    // abort beats a simultaneous valid in IDLE
    valid = 1'b1; letter = 5'd4; abort = 1'b1;
    push(0, 0, 0, 0, 1, 3);
    run_sb("abort_idle", 0, 0, 0);

    // T then E with valid held: E accepted in T's done cycle
    valid = 1'b1; letter = 5'd19;
    push_letter("-", 1'b0);
    push_letter(".", 1'b0);
    run_sb("b2b", 0, 101, 5'd4);

    // async reset mid-letter
    valid = 1'b1; letter = 5'd1;
    push(1, 1, 0, 0, 0, 10);
    run_sb("pre_rst", 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_rst", 0, {key, busy, done, err, ready}, 5'b00001);
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 0, 0, 0, 1, 4);
    run_sb("post_rst", 0, 0, 0);

`ifdef MORSE_TX_REPEAT_EN
    rpt = 1'b1; valid = 1'b1; letter = 5'd19;
    push(1, 1, 0, 0, 0, 60);
    push(0, 1, 0, 0, 0, 40);
    push(1, 1, 1, 0, 0, 1);
    push(1, 1, 0, 0, 0, 59);
    push(0, 1, 0, 0, 0, 40);
    push(1, 1, 1, 0, 0, 1);
    push(0, 0, 0, 0, 1, 2);
    run_sb("repeat_t", 201, 0, 0);
    rpt = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
